// File: rtl/decode_src_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : decode_src_ctrl
// Brief   : Source-side job controller for the decoder: tracks remaining 64-bit
//           words, flushes leftovers after an early end-of-stream, and times out
//           a missing end-of-stream. Optional RUN cycle counter under macro
//           DECODE_SRC_CTRL_STAT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module decode_src_ctrl #(
   parameter int CNT_WIDTH = 20,
   parameter int TO_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] src_len,
   input  logic                 abort,
   input  logic                 m_src_empty,
   input  logic                 dp_getn,
   input  logic                 dec_done,
   output logic                 ce,
   output logic                 m_last,
   output logic                 flush_getn,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [CNT_WIDTH-3:0] words_left,
   output logic [31:0]          stat_cycles
);

   localparam int c_ww   = CNT_WIDTH - 2;
   localparam int c_to_w = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
   localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TO_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_WAIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_ww-1:0]     r_words, w_words_nxt, w_words_dec, w_len_words;
   logic [c_to_w-1:0]   r_to_cnt, w_to_nxt;
   logic                r_err, w_err_nxt;
   logic                r_ce, r_busy, r_done, r_m_last;
   logic                w_pop, w_flush_pop;

   // Round the byte count up to whole 64-bit words.
   assign w_len_words = {1'b0, src_len[CNT_WIDTH-1:3]}
                      + {{(c_ww-1){1'b0}}, |src_len[2:0]};

   assign w_pop       = !dp_getn && ((r_state == S_LOAD) || (r_state == S_RUN))
                        && (r_words != '0);
   assign w_flush_pop = (r_state == S_FLUSH) && !m_src_empty && (r_words != '0) && !abort;
   assign w_words_dec = (w_pop || w_flush_pop) ? (r_words - c_ww'(1)) : r_words;

   always_comb begin
      w_state_nxt = r_state;
      w_words_nxt = w_words_dec;
      w_err_nxt   = r_err;
      w_to_nxt    = r_to_cnt;
      if (abort) begin
         w_state_nxt = S_IDLE;
         w_words_nxt = r_words;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_err_nxt   = 1'b0;
                  w_words_nxt = w_len_words;
                  w_state_nxt = (src_len == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: w_state_nxt = S_RUN;
            S_RUN: begin
               // A same-cycle pop is already folded into w_words_dec.
               if (dec_done) begin
                  if (w_words_dec == '0) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = S_FLUSH;
                  end
               end else if (r_words == '0) begin
                  w_state_nxt = S_WAIT;
                  w_to_nxt    = '0;
               end
            end
            S_WAIT: begin
               if (!dp_getn) w_err_nxt = 1'b1;
               if (dec_done) begin
                  w_state_nxt = S_DONE;
               end else if (r_to_cnt == c_to_last) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_to_nxt = r_to_cnt + c_to_w'(1);
               end
            end
            S_FLUSH: begin
               if (w_words_dec == '0) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_words  <= '0;
         r_err    <= 1'b0;
         r_to_cnt <= '0;
         r_ce     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_m_last <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_words  <= w_words_nxt;
         r_err    <= w_err_nxt;
         r_to_cnt <= w_to_nxt;
         r_ce     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
         r_busy   <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN)
                  || (w_state_nxt == S_FLUSH) || (w_state_nxt == S_WAIT);
         r_done   <= (w_state_nxt == S_DONE);
         r_m_last <= ((w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN)
                  || (w_state_nxt == S_WAIT)) && (w_words_nxt <= c_ww'(1));
      end
   end

   assign ce         = r_ce;
   assign busy       = r_busy;
   assign done       = r_done;
   assign m_last     = r_m_last;
   assign err        = r_err;
   assign words_left = r_words;
   assign flush_getn = !w_flush_pop;

`ifdef DECODE_SRC_CTRL_STAT_EN
   logic [31:0] r_stat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat <= '0;
      end else if ((r_state == S_IDLE) && start && !abort) begin
         r_stat <= '0;
      end else if (r_state == S_RUN) begin
         r_stat <= r_stat + 32'd1;
      end
   end

   assign stat_cycles = r_stat;
`else
   assign stat_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_src_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_decode_src_ctrl
// Brief   : Directed bench for decode_src_ctrl with a cycle-level reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decode_src_ctrl;

   localparam int CW = 20;
   localparam int TO = 256;
   localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_FLUSH = 3, P_WAIT = 4, P_DONE = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0, abort = 1'b0, dp_getn = 1'b1, dec_done = 1'b0;
   logic [CW-1:0] src_len = '0;
   logic          m_src_empty;
   logic          ce, m_last, flush_getn, busy, done, err;
   logic [CW-3:0] words_left;
   logic [31:0]   stat_cycles;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   decode_src_ctrl #(.CNT_WIDTH(CW), .TO_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src_len(src_len), .abort(abort),
      .m_src_empty(m_src_empty), .dp_getn(dp_getn), .dec_done(dec_done),
      .ce(ce), .m_last(m_last), .flush_getn(flush_getn), .busy(busy), .done(done),
      .err(err), .words_left(words_left), .stat_cycles(stat_cycles)
   );

   // Source FIFO occupancy: fill level set by stimulus, drained by flush pops.
   int fifo_fill = 0;
   int fifo_pops = 0;
   assign m_src_empty = (fifo_pops >= fifo_fill);
   always @(posedge clk) if (!flush_getn) fifo_pops <= fifo_pops + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: job phase, words remaining, sticky error, timeout, RUN count.
   int     m_ph = P_IDLE, m_words = 0, m_to = 0;
   bit     m_err = 1'b0;
   longint m_stat = 0;

   always @(posedge clk or negedge rst_n) begin : model
      automatic int     ph, w, to;
      automatic bit     e, was0;
      automatic longint st;
      if (!rst_n) begin
         m_ph <= P_IDLE; m_words <= 0; m_to <= 0; m_err <= 1'b0; m_stat <= 0;
      end else begin
         ph = m_ph; w = m_words; to = m_to; e = m_err; st = m_stat;
         if (m_ph == P_RUN) st = st + 1;
         else if (m_ph == P_IDLE && start && !abort) st = 0;
         if (abort) ph = P_IDLE;
         else case (m_ph)
            P_IDLE: if (start) begin
               e  = 1'b0;
               w  = (int'(src_len) + 7) / 8;
               ph = (src_len == 0) ? P_DONE : P_LOAD;
            end
            P_LOAD: begin
               if (!dp_getn && w > 0) w = w - 1;
               ph = P_RUN;
            end
            P_RUN: begin
               was0 = (w == 0);
               if (!dp_getn && w > 0) w = w - 1;
               if (dec_done) begin
                  if (w == 0) ph = P_DONE;
                  else begin e = 1'b1; ph = P_FLUSH; end
               end else if (was0) begin
                  ph = P_WAIT; to = 0;
               end
            end
            P_WAIT: begin
               if (!dp_getn) e = 1'b1;
               if (dec_done) ph = P_DONE;
               else if (to == TO - 1) begin e = 1'b1; ph = P_DONE; end
               else to = to + 1;
            end
            P_FLUSH: if (!m_src_empty && w > 0) begin
               w = w - 1;
               if (w == 0) ph = P_DONE;
            end
            default: ph = P_IDLE;
         endcase
         m_ph <= ph; m_words <= w; m_to <= to; m_err <= e; m_stat <= st;
      end
   end

   longint exp_stat;
`ifdef DECODE_SRC_CTRL_STAT_EN
   assign exp_stat = m_stat;
`else
   assign exp_stat = 0;
`endif

   always @(negedge clk) begin : compare
      chk("ce", ce, (m_ph == P_LOAD || m_ph == P_RUN));
      chk("busy", busy, (m_ph == P_LOAD || m_ph == P_RUN || m_ph == P_FLUSH || m_ph == P_WAIT));
      chk("done", done, (m_ph == P_DONE));
      chk("m_last", m_last, ((m_ph == P_LOAD || m_ph == P_RUN || m_ph == P_WAIT) && m_words <= 1));
      chk("flush_getn", flush_getn, !(m_ph == P_FLUSH && !m_src_empty && m_words > 0 && !abort));
      chk("err", err, m_err);
      chk("words_left", words_left, m_words);
      chk("stat_cycles", stat_cycles, exp_stat);
   end

   // Observation counters for scenario-level literal checks.
   int n_done = 0, n_flush = 0, n_busy_noce = 0;
   always @(negedge clk) begin
      if (done) n_done <= n_done + 1;
      if (!flush_getn) n_flush <= n_flush + 1;
      if (busy && !ce) n_busy_noce <= n_busy_noce + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int max, input string nm);
      int k = 0;
      while (!done && k < max) begin cyc(); k++; end
      chk(nm, done, 1'b1);
   endtask

   task automatic start_job(input int len);
      src_len = CW'(len);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      int d0, f0, w0;
      #2 rst_n = 1'b0;
      cyc();
      chk("reset busy", busy, 0);
      chk("reset flush_getn", flush_getn, 1);
      chk("reset words_left", words_left, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // 64 bytes, one pop per cycle, dec_done the cycle after the 8th pop
      d0 = n_done;
      start_job(64);
      chk("S1 words init", words_left, 8);
      cyc();
      for (int i = 0; i < 8; i++) begin
         dp_getn = 1'b0;
         cyc();
         if (i == 5) chk("S1 m_last at 2", m_last, 0);
         if (i == 6) begin chk("S1 words at 1", words_left, 1); chk("S1 m_last at 1", m_last, 1); end
      end
      dp_getn = 1'b1;
      dec_done = 1'b1;
      cyc();
      dec_done = 1'b0;
      chk("S1 done", done, 1);
      cyc();
      chk("S1 done count", n_done - d0, 1);
      chk("S1 err", err, 0);

      // 20 bytes, dec_done with the 3rd pop: no WAIT_EOS
      w0 = n_busy_noce;
      start_job(20);
      chk("S2 words init", words_left, 3);
      cyc();
      dp_getn = 1'b0;
      cyc(); cyc();
      dec_done = 1'b1;
      cyc();
      dp_getn = 1'b1; dec_done = 1'b0;
      chk("S2 done", done, 1);
      chk("S2 err", err, 0);
      cyc();
      chk("S2 no wait cycles", n_busy_noce - w0, 0);

      // 80 bytes, 4 pops, early dec_done, 6 words left in FIFO
      d0 = n_done; f0 = n_flush;
      fifo_fill = fifo_pops + 6;
      start_job(80);
      chk("S3 words init", words_left, 10);
      cyc();
      dp_getn = 1'b0;
      repeat (4) cyc();
      dp_getn = 1'b1;
      dec_done = 1'b1;
      cyc();
      dec_done = 1'b0;
      chk("S3 err set", err, 1);
      wait_done(50, "S3 done timeout");
      chk("S3 flush pulses", n_flush - f0, 6);
      chk("S3 words end", words_left, 0);
      cyc();
      chk("S3 done count", n_done - d0, 1);

      // 8 bytes, one pop plus a saturating extra pop, no dec_done -> timeout
      w0 = n_busy_noce;
      start_job(8);
      chk("S4 words init", words_left, 1);
      chk("S4 m_last in LOAD", m_last, 1);
      cyc();
      dp_getn = 1'b0;
      cyc(); cyc();
      dp_getn = 1'b1;
      chk("S4 words saturate", words_left, 0);
      wait_done(300, "S4 done timeout");
      chk("S4 err", err, 1);
      chk("S4 wait cycles", n_busy_noce - w0, 256);
      cyc();

      // zero-length job clears err; start held into DONE is ignored
      d0 = n_done;
      src_len = '0;
      start = 1'b1;
      cyc();
      chk("S6 done", done, 1);
      chk("S6 err cleared", err, 0);
      cyc();
      start = 1'b0;
      chk("S6 idle after done", busy, 0);
      cyc();
      chk("S6 done count", n_done - d0, 1);

      // abort in RUN with 5 words left, abort+start in IDLE, then zero-length job
      start_job(80);
      cyc();
      dp_getn = 1'b0;
      repeat (5) cyc();
      dp_getn = 1'b1;
      chk("S5 words before abort", words_left, 5);
      d0 = n_done;
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("S5 busy after abort", busy, 0);
      chk("S5 words held", words_left, 5);
      abort = 1'b1; src_len = CW'(16); start = 1'b1;
      cyc();
      abort = 1'b0; start = 1'b0;
      chk("S5 abort beats start", busy, 0);
      start_job(0);
      chk("S5 second done", done, 1);
      chk("S5 err", err, 0);
      cyc();
      chk("S5 done count", n_done - d0, 1);

      // 10-cycle RUN job for the statistics counter
      start_job(80);
      cyc();
      for (int i = 0; i < 10; i++) begin
         dp_getn = 1'b0;
         dec_done = (i == 9);
         cyc();
      end
      dp_getn = 1'b1; dec_done = 1'b0;
      chk("S8 done", done, 1);
`ifdef DECODE_SRC_CTRL_STAT_EN
      chk("S8 stat_cycles", stat_cycles, 10);
`else
      chk("S8 stat_cycles", stat_cycles, 0);
`endif
      cyc();

      // reset pulsed mid-RUN
      start_job(64);
      cyc();
      dp_getn = 1'b0;
      repeat (3) cyc();
      dp_getn = 1'b1;
      d0 = n_done;
      rst_n = 1'b0;
      #1;
      chk("S7 ce in reset", ce, 0);
      chk("S7 busy in reset", busy, 0);
      chk("S7 words in reset", words_left, 0);
      chk("S7 stat in reset", stat_cycles, 0);
      cyc(); cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("S7 no done", n_done - d0, 0);
      chk("S7 idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_src_ctrl.md
DECODE_SRC_CTRL -- requirements
Module: decode_src_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 20, the width of the source byte count.
REQ-002 SHALL have parameter TO_CYCLES, default 256, the end-of-stream timeout in cycles after the last word is popped.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  job start pulse; honoured only in IDLE.
REQ-006 SHALL have port src_len  input  CNT_WIDTH  job length in bytes; sampled when start is accepted.
REQ-007 SHALL have port abort  input  1  cancels the job from any state.
REQ-008 SHALL have port m_src_empty  input  1  source 64-bit FIFO empty.
REQ-009 SHALL have port dp_getn  input  1  active-low pop strobe issued by the decode input datapath.
REQ-010 SHALL have port dec_done  input  1  decoder saw the end-of-stream marker.
REQ-011 SHALL have port ce  output  1  datapath enable.
REQ-012 SHALL have port m_last  output  1  the final source word is the next or current word consumed.
REQ-013 SHALL have port flush_getn  output  1  active-low FIFO pop driven by this block while flushing.
REQ-014 SHALL have port busy  output  1  job in progress.
REQ-015 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-016 SHALL have port err  output  1  sticky job error; cleared when start is accepted.
REQ-017 SHALL have port words_left  output  CNT_WIDTH-2  source words not yet popped.
REQ-018 SHALL have port stat_cycles  output  32  RUN-state cycle count.

Function
REQ-019 SHALL implement the states IDLE, LOAD, RUN, FLUSH, WAIT_EOS and DONE.
REQ-020 IDLE: on start, SHALL load words_left = (src_len+7)>>3 and go to LOAD; if src_len==0, SHALL go directly to DONE with err=0.
REQ-021 LOAD: SHALL assert ce and go to RUN after exactly one cycle.
REQ-022 RUN: SHALL hold ce=1 and busy=1, and SHALL decrement words_left by 1 on each cycle with dp_getn==0; words_left SHALL saturate at 0.
REQ-023 m_last SHALL equal (words_left<=1) during LOAD, RUN and WAIT_EOS, and SHALL be 0 in all other states.
REQ-024 RUN with words_left==0 and dec_done==0: SHALL go to WAIT_EOS and start the timeout counter at 0.
REQ-025 WAIT_EOS: dec_done SHALL cause a transition to DONE; a timeout counter reaching TO_CYCLES-1 SHALL set err and cause a transition to DONE.
REQ-026 RUN with dec_done and words_left==0: SHALL go to DONE with err unchanged.
REQ-027 RUN with dec_done and words_left>0: SHALL set err, drop ce, and go to FLUSH.
REQ-028 FLUSH: SHALL drive flush_getn=0 on each cycle with m_src_empty==0, SHALL decrement words_left per pop, and SHALL go to DONE when words_left reaches 0.
REQ-029 flush_getn SHALL be 1 in every state except FLUSH.
REQ-030 A pop (dp_getn==0) and dec_done in the same cycle: SHALL count the pop first, then evaluate dec_done against the decremented words_left.
REQ-031 dp_getn==0 outside LOAD and RUN SHALL be ignored; if it arrives in WAIT_EOS it SHALL set err.
REQ-032 DONE: SHALL assert done=1 for exactly one cycle, SHALL have ce=0 and busy=0, and SHALL go to IDLE; start in DONE SHALL be ignored.
REQ-033 abort in any state SHALL force IDLE on the next edge, with ce=0, flush_getn=1, no done pulse, and err and words_left held.
REQ-034 abort and start in the same cycle: abort SHALL take priority.
REQ-035 busy SHALL be 1 in the LOAD, RUN, FLUSH and WAIT_EOS states.

Reset
REQ-036 rst_n low SHALL force IDLE immediately, with ce=0, m_last=0, flush_getn=1, busy=0, done=0, err=0, words_left=0, stat_cycles=0 and the timeout counter at 0.
REQ-037 Reset asserted mid-job SHALL discard the job; after release the block SHALL wait for a new start.

Configuration
REQ-038 With macro DECODE_SRC_CTRL_STAT_EN defined, stat_cycles SHALL clear on accepted start, increment once per RUN cycle, and hold its value through DONE and IDLE.
REQ-039 Without DECODE_SRC_CTRL_STAT_EN, the stat_cycles port SHALL remain present and be tied to 0, and no counter logic SHALL be built.

Verification
REQ-040 src_len=64 with one pop per cycle and dec_done on the cycle after the 8th pop -> words_left 8 down to 0, m_last high from words_left==1, single done pulse, err=0.
REQ-041 src_len=20 (3 words), dec_done asserted together with the 3rd pop -> direct RUN to DONE, err=0, no WAIT_EOS entry.
REQ-042 src_len=80, dec_done after 4 pops, FIFO holding 6 words -> FLUSH issues 6 flush_getn pulses, words_left reaches 0, done pulse, err=1.
REQ-043 src_len=8, one pop, dec_done never asserted -> WAIT_EOS for 256 cycles, then err=1 and a done pulse.
REQ-044 abort asserted in RUN with words_left=5, then start with src_len=0 -> IDLE with no done pulse; the second job gives done the cycle after start, with err cleared.
REQ-045 rst_n pulsed low mid-RUN -> all outputs at reset values while low, with no done pulse; with DECODE_SRC_CTRL_STAT_EN, stat_cycles=10 after a 10-cycle RUN job.
